// File: rtl/des_pkg.sv
// Shared constants for the DES key schedule: widths, FIPS-46 permutation/shift tables,
// FSM state type and the bit-level helpers used by the schedule datapath.
package des_pkg;

    localparam int unsigned KEY_W    = 64;
    localparam int unsigned CD_W     = 28;
    localparam int unsigned SUBKEY_W = 48;

    // Left-rotate amount of C/D ahead of round r+1.
    localparam int unsigned SHIFT_TBL [16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // Entries are 1-based FIPS bit numbers of the source vector.
    localparam int unsigned PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } ks_state_e;

    // Result index j holds CD bit j+1: C in [27:0], D in [55:28].
    function automatic logic [2*CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
        logic [2*CD_W-1:0] cd;
        cd = '0;
        for (int unsigned j = 0; j < 2 * CD_W; j++) begin
            cd[j] = key[6'(PC1_TBL[j] - 1)];
        end
        return cd;
    endfunction

    // FIPS bit 1 sits at index 0, so a FIPS left rotate moves bits toward lower indices.
    function automatic logic [CD_W-1:0] rotl_fips(input logic [CD_W-1:0] v, input logic two);
        return two ? {v[1:0], v[CD_W-1:2]} : {v[0], v[CD_W-1:1]};
    endfunction

    function automatic logic [CD_W-1:0] rotr_fips(input logic [CD_W-1:0] v, input logic two);
        return two ? {v[CD_W-3:0], v[CD_W-1:CD_W-2]} : {v[CD_W-2:0], v[CD_W-1]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// DES permuted choice 2: combinational 56->48 selection from the C/D halves.
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0]     c,
    input  logic [CD_W-1:0]     d,
    output logic [SUBKEY_W-1:0] subkey
);

    logic [2*CD_W-1:0] cd;

    always_comb begin
        cd     = {d, c};
        subkey = '0;
        for (int unsigned j = 0; j < SUBKEY_W; j++) begin
            subkey[j] = cd[6'(PC2_TBL[j] - 1)];
        end
    end

endmodule

// File: rtl/des_dec_key_sched.sv
// DES key schedule: loads a 64-bit key and streams K16..K1 over valid/ready.
// Optional DES_KS_ENC_EN adds the enc_mode port selecting K1..K16 encryption order.
module des_dec_key_sched
    import des_pkg::*;
#(
    parameter int unsigned NROUNDS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                key_valid,
`ifdef DES_KS_ENC_EN
    input  logic                enc_mode,
`endif
    output logic                key_ready,
    output logic [SUBKEY_W-1:0] subkey,
    output logic [3:0]          subkey_round,
    output logic                subkey_valid,
    input  logic                subkey_ready,
    output logic                subkey_last,
    output logic                busy
);

    localparam logic [3:0] CNT_TOP = 4'(NROUNDS - 1);

    ks_state_e         state_q, state_d;
    logic [CD_W-1:0]   c_q, c_d;
    logic [CD_W-1:0]   d_q, d_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              key_ready_q, key_ready_d;
    logic              subkey_valid_q, subkey_valid_d;
    logic              subkey_last_q, subkey_last_d;
    logic              busy_q, busy_d;
    logic [2*CD_W-1:0] cd_load;
    logic [3:0]        cnt_end;
    logic              enc_load;
    logic              enc_run;

`ifdef DES_KS_ENC_EN
    logic enc_q, enc_d;

    always_comb begin
        enc_load = enc_mode;
        enc_run  = enc_q;
    end
`else
    always_comb begin
        enc_load = 1'b0;
        enc_run  = 1'b0;
    end
`endif

    always_comb begin
        state_d        = state_q;
        c_d            = c_q;
        d_d            = d_q;
        cnt_d          = cnt_q;
        key_ready_d    = key_ready_q;
        subkey_valid_d = subkey_valid_q;
        subkey_last_d  = subkey_last_q;
        busy_d         = busy_q;
`ifdef DES_KS_ENC_EN
        enc_d          = enc_q;
`endif
        cd_load = pc1(key_in);
        cnt_end = enc_run ? CNT_TOP : '0;

        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    state_d        = ST_EMIT;
                    key_ready_d    = 1'b0;
                    subkey_valid_d = 1'b1;
                    subkey_last_d  = 1'b0;
                    busy_d         = 1'b1;
`ifdef DES_KS_ENC_EN
                    enc_d          = enc_mode;
`endif
                    // Decryption starts from C16/D16, which equal PC-1 since the shifts total 28.
                    if (enc_load) begin
                        c_d   = rotl_fips(cd_load[CD_W-1:0], SHIFT_TBL[0] == 2);
                        d_d   = rotl_fips(cd_load[2*CD_W-1:CD_W], SHIFT_TBL[0] == 2);
                        cnt_d = '0;
                    end else begin
                        c_d   = cd_load[CD_W-1:0];
                        d_d   = cd_load[2*CD_W-1:CD_W];
                        cnt_d = CNT_TOP;
                    end
                end
            end
            ST_EMIT: begin
                if (subkey_ready) begin
                    if (cnt_q == cnt_end) begin
                        state_d        = ST_IDLE;
                        key_ready_d    = 1'b1;
                        subkey_valid_d = 1'b0;
                        subkey_last_d  = 1'b0;
                        busy_d         = 1'b0;
                    end else begin
                        if (enc_run) begin
                            c_d   = rotl_fips(c_q, SHIFT_TBL[cnt_q + 4'd1] == 2);
                            d_d   = rotl_fips(d_q, SHIFT_TBL[cnt_q + 4'd1] == 2);
                            cnt_d = cnt_q + 4'd1;
                        end else begin
                            c_d   = rotr_fips(c_q, SHIFT_TBL[cnt_q] == 2);
                            d_d   = rotr_fips(d_q, SHIFT_TBL[cnt_q] == 2);
                            cnt_d = cnt_q - 4'd1;
                        end
                        subkey_last_d = (cnt_d == cnt_end);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            c_q            <= '0;
            d_q            <= '0;
            cnt_q          <= '0;
            key_ready_q    <= 1'b1;
            subkey_valid_q <= 1'b0;
            subkey_last_q  <= 1'b0;
            busy_q         <= 1'b0;
`ifdef DES_KS_ENC_EN
            enc_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            c_q            <= c_d;
            d_q            <= d_d;
            cnt_q          <= cnt_d;
            key_ready_q    <= key_ready_d;
            subkey_valid_q <= subkey_valid_d;
            subkey_last_q  <= subkey_last_d;
            busy_q         <= busy_d;
`ifdef DES_KS_ENC_EN
            enc_q          <= enc_d;
`endif
        end
    end

    // Subkey is taken straight off the C/D registers; with C/D cleared it reads zero.
    des_pc2 u_pc2 (
        .c      (c_q),
        .d      (d_q),
        .subkey (subkey)
    );

    always_comb begin
        key_ready    = key_ready_q;
        subkey_valid = subkey_valid_q;
        subkey_last  = subkey_last_q;
        subkey_round = cnt_q;
        busy         = busy_q;
    end

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Self-checking bench for des_dec_key_sched; the reference model computes subkeys the
// textbook way on MSB-first FIPS numbers. Define DES_KS_ENC_EN to also cover enc_mode.
module tb_des_dec_key_sched;

    localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] KAT_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] KAT_K16 = 48'hCB3D8B0E17F5;
    localparam logic [63:0] PARITY  = 64'h0101010101010101;

    localparam int unsigned SHIFT_REF [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    localparam int unsigned PC1_REF [56] = '{
        57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
    localparam int unsigned PC2_REF [48] = '{
        14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
        41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key_in;
    logic        key_valid;
    logic        key_ready;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        subkey_last;
    logic        busy;
`ifdef DES_KS_ENC_EN
    logic        enc_mode = 1'b0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    des_dec_key_sched #(.NROUNDS(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .key_valid    (key_valid),
`ifdef DES_KS_ENC_EN
        .enc_mode     (enc_mode),
`endif
        .key_ready    (key_ready),
        .subkey       (subkey),
        .subkey_round (subkey_round),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey_last  (subkey_last),
        .busy         (busy)
    );

    // Round r (1..16) subkey; key given MSB-first (FIPS bit 1 = bit 63), result in DUT vector order.
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int unsigned r);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        int unsigned total;
        cd = '0;
        for (int j = 0; j < 56; j++) cd = {cd[54:0], 1'(key >> (64 - PC1_REF[j]))};
        c = cd[55:28];
        d = cd[27:0];
        total = 0;
        for (int unsigned i = 0; i < r; i++) total += SHIFT_REF[i];
        for (int unsigned s = 0; s < total; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        k = '0;
        for (int j = 0; j < 48; j++) k = {k[46:0], 1'(cd >> (56 - PC2_REF[j]))};
        return {<<{k}};
    endfunction

    function automatic logic [47:0] fips48(input logic [47:0] v);
        return {<<{v}};
    endfunction

    task automatic start_key(input logic [63:0] key_fips);
        key_in    = {<<{key_fips}};
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_valid = 1'b0;
        subkey_ready = 1'b0;
        key_in = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (key_ready !== 1'b1 || subkey_valid !== 1'b0 || subkey !== 48'h0 || subkey_round !== 4'd0
            || subkey_last !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: ready=%b valid=%b subkey=%h round=%0d last=%b busy=%b, want 1 0 0 0 0 0",
                     key_ready, subkey_valid, subkey, subkey_round, subkey_last, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (key_ready !== 1'b1 || subkey_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b valid=%b, want 1 0", key_ready, subkey_valid);
        end
    endtask

    task automatic test_fips_vector(input string name, input logic [63:0] key, input logic [63:0] ref_key,
                                    input bit glitch_key);
        logic [47:0] exp;
        subkey_ready = 1'b1;
        tests_run++;
        if (key_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_idle: key_ready=%b, want 1", name, key_ready);
        end
        start_key(key);
        for (int b = 0; b < 16; b++) begin
            if (glitch_key && b == 5) begin key_valid = 1'b1; key_in = '0; end
            if (glitch_key && b == 6) key_valid = 1'b0;
            exp = ref_subkey(ref_key, 16 - b);
            tests_run++;
            if (subkey_valid !== 1'b1 || subkey_round !== 4'(15 - b) || subkey !== exp
                || subkey_last !== (b == 15) || busy !== 1'b1 || key_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_beat%0d: valid=%b round=%0d subkey=%h last=%b busy=%b kr=%b, want 1 %0d %h %b 1 0",
                         name, b, subkey_valid, subkey_round, subkey, subkey_last, busy, key_ready,
                         15 - b, exp, b == 15);
            end
            if (b == 0 || b == 15) begin
                exp = (b == 0) ? fips48(KAT_K16) : fips48(KAT_K1);
                tests_run++;
                if (ref_key == KAT_KEY && subkey !== exp) begin
                    tests_failed++;
                    $display("FAIL %s_kat%0d: subkey=%h, want %h", name, b, subkey, exp);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (subkey_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_done: valid=%b ready=%b busy=%b, want 0 1 0", name, subkey_valid, key_ready, busy);
        end
        @(negedge clk);
        tests_run++;
        if (subkey_valid !== 1'b0 || key_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_stay_idle: valid=%b ready=%b, want 0 1", name, subkey_valid, key_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] exp;
        int beat = 0;
        int cyc = 0;
        start_key(KAT_KEY);
        while (beat < 16 && cyc < 64) begin
            subkey_ready = (cyc % 2 == 0);
            exp = ref_subkey(KAT_KEY, 16 - beat);
            tests_run++;
            if (subkey_valid !== 1'b1 || subkey_round !== 4'(15 - beat) || subkey !== exp
                || subkey_last !== (beat == 15)) begin
                tests_failed++;
                $display("FAIL bp_cyc%0d: valid=%b round=%0d subkey=%h last=%b, want 1 %0d %h %b",
                         cyc, subkey_valid, subkey_round, subkey, subkey_last, 15 - beat, exp, beat == 15);
            end
            if (subkey_ready) beat++;
            cyc++;
            @(negedge clk);
        end
        subkey_ready = 1'b1;
        tests_run++;
        if (cyc != 31 || subkey_valid !== 1'b0 || key_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_total: cycles=%0d valid=%b ready=%b, want 31 0 1", cyc, subkey_valid, key_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] key;
        logic [47:0] exp;
        key = {$urandom, $urandom};
        subkey_ready = 1'b1;
        start_key(key);
        for (int b = 0; b < 8; b++) begin
            exp = ref_subkey(key, 16 - b);
            tests_run++;
            if (subkey_valid !== 1'b1 || subkey !== exp || subkey_round !== 4'(15 - b)) begin
                tests_failed++;
                $display("FAIL rstmid_beat%0d: valid=%b subkey=%h round=%0d, want 1 %h %0d",
                         b, subkey_valid, subkey, subkey_round, exp, 15 - b);
            end
            if (b < 7) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (subkey_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0 || subkey !== 48'h0
            || subkey_round !== 4'd0 || subkey_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_abort: valid=%b ready=%b busy=%b subkey=%h round=%0d last=%b, want 0 1 0 0 0 0",
                     subkey_valid, key_ready, busy, subkey, subkey_round, subkey_last);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        key = {$urandom, $urandom};
        test_fips_vector("after_rst", key, key, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] key;
        logic [47:0] exp;
        int beat;
        int cyc;
        for (int k = 0; k < 4; k++) begin
            key = {$urandom, $urandom};
            tests_run++;
            if (key_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_ready%0d: key_ready=%b, want 1", k, key_ready);
            end
            start_key(key);
            beat = 0;
            cyc = 0;
            while (beat < 16 && cyc < 200) begin
                subkey_ready = ($urandom_range(3) != 0);
                exp = ref_subkey(key, 16 - beat);
                tests_run++;
                if (subkey_valid !== 1'b1 || subkey_round !== 4'(15 - beat) || subkey !== exp
                    || subkey_last !== (beat == 15)) begin
                    tests_failed++;
                    $display("FAIL b2b_k%0d_beat%0d: valid=%b round=%0d subkey=%h last=%b, want 1 %0d %h %b",
                             k, beat, subkey_valid, subkey_round, subkey, subkey_last, 15 - beat, exp, beat == 15);
                end
                if (subkey_ready) beat++;
                cyc++;
                @(negedge clk);
            end
            tests_run++;
            if (beat != 16 || subkey_valid !== 1'b0 || key_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_end%0d: beats=%0d valid=%b ready=%b, want 16 0 1", k, beat, subkey_valid, key_ready);
            end
        end
        subkey_ready = 1'b1;
    endtask

`ifdef DES_KS_ENC_EN
    task automatic test_enc();
        logic [47:0] exp;
        subkey_ready = 1'b1;
        enc_mode = 1'b1;
        start_key(KAT_KEY);
        enc_mode = 1'b0;
        for (int b = 0; b < 16; b++) begin
            exp = ref_subkey(KAT_KEY, b + 1);
            tests_run++;
            if (subkey_valid !== 1'b1 || subkey_round !== 4'(b) || subkey !== exp || subkey_last !== (b == 15)) begin
                tests_failed++;
                $display("FAIL enc_beat%0d: valid=%b round=%0d subkey=%h last=%b, want 1 %0d %h %b",
                         b, subkey_valid, subkey_round, subkey, subkey_last, b, exp, b == 15);
            end
            if (b == 0 || b == 15) begin
                exp = (b == 0) ? fips48(KAT_K1) : fips48(KAT_K16);
                tests_run++;
                if (subkey !== exp) begin
                    tests_failed++;
                    $display("FAIL enc_kat%0d: subkey=%h, want %h", b, subkey, exp);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (subkey_valid !== 1'b0 || key_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL enc_done: valid=%b ready=%b, want 0 1", subkey_valid, key_ready);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fips_vector("fips", KAT_KEY, KAT_KEY, 1'b0);
        test_backpressure();
        test_fips_vector("ignore_key", KAT_KEY, KAT_KEY, 1'b1);
        test_reset_mid();
        test_fips_vector("parity", KAT_KEY ^ PARITY, KAT_KEY, 1'b0);
        test_back_to_back();
`ifdef DES_KS_ENC_EN
        test_enc();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
